pipe_hazard_unit: RTL and testbench

// - Hazard/forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// - Keeps a shadow scoreboard of the instructions in ID/EX, EX/MEM and MEM/WB.
// - Drives load-use stalls, RAW stalls (forwarding off), branch flushes and EX operand-forward selects.
// - Counts stall and flush events; sits beside the pipeline registers, driven by main_control/ID decode.

---
 rtl/mips_pipe_pkg.sv | 35 +++
 rtl/hz_src_match.sv | 16 +
 rtl/pipe_hazard_unit.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard/forwarding logic: shadow entry layout,
// forward-select encoding and the forward priority helper.
package mips_pipe_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_NONE = '0;

    // The youngest producer wins; a load still in MEM has no data to give yet.
    function automatic fwd_sel_t pick_fwd(input logic mem_hit, input logic mem_load,
                                          input logic wb_hit);
        if (mem_hit && !mem_load) return FWD_MEM;
        if (wb_hit) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_src_match.sv
// Compares one in-flight writer against one source register; register 0 never matches.
module hz_src_match
    import mips_pipe_pkg::*;
(
    input  logic              writer_valid,
    input  logic              writer_reg_write,
    input  logic [REG_AW-1:0] writer_rd,
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    output logic              match
);

    assign match = writer_valid && writer_reg_write && use_src
                   && (writer_rd == src) && (writer_rd != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: shadow scoreboard of
// ID/EX, EX/MEM, MEM/WB, stall/flush decode, EX operand forward selects, event counters.
module pipe_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int RA_W      = REG_AW,
    parameter int FWD_EN    = 1,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    shadow_entry_t s_ex, s_mem, s_wb, id_entry;
    shadow_entry_t stage [3];
    logic [2:0] id_rs_hit, id_rt_hit;
    logic [1:0] ex_rs_hit, ex_rt_hit;
    logic       load_use, raw_any, hazard, stall, flush;

    assign stage[0] = s_ex;
    assign stage[1] = s_mem;
    assign stage[2] = s_wb;

    // Index 0/1/2 = writer in EX/MEM/WB against the ID instruction's sources.
    for (genvar g = 0; g < 3; g++) begin : g_id_match
        hz_src_match u_rs (
            .writer_valid    (stage[g].valid),
            .writer_reg_write(stage[g].reg_write),
            .writer_rd       (stage[g].rd),
            .src             (id_rs),
            .use_src         (id_use_rs),
            .match           (id_rs_hit[g])
        );
        hz_src_match u_rt (
            .writer_valid    (stage[g].valid),
            .writer_reg_write(stage[g].reg_write),
            .writer_rd       (stage[g].rd),
            .src             (id_rt),
            .use_src         (id_use_rt),
            .match           (id_rt_hit[g])
        );
    end

    // Index 0/1 = writer in MEM/WB against the EX instruction's sources.
    for (genvar g = 0; g < 2; g++) begin : g_ex_match
        hz_src_match u_rs (
            .writer_valid    (stage[g+1].valid),
            .writer_reg_write(stage[g+1].reg_write),
            .writer_rd       (stage[g+1].rd),
            .src             (s_ex.rs),
            .use_src         (s_ex.use_rs),
            .match           (ex_rs_hit[g])
        );
        hz_src_match u_rt (
            .writer_valid    (stage[g+1].valid),
            .writer_reg_write(stage[g+1].reg_write),
            .writer_rd       (stage[g+1].rd),
            .src             (s_ex.rt),
            .use_src         (s_ex.use_rt),
            .match           (ex_rt_hit[g])
        );
    end

    always_comb begin
        id_entry           = SHADOW_NONE;
        id_entry.valid     = id_valid;
        id_entry.rs        = id_rs;
        id_entry.rt        = id_rt;
        id_entry.use_rs    = id_use_rs;
        id_entry.use_rt    = id_use_rt;
        id_entry.rd        = id_rd;
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
    end

    assign load_use = s_ex.mem_read && (id_rs_hit[0] || id_rt_hit[0]);
    assign raw_any  = id_rs_hit[0] || id_rt_hit[0] || id_rs_hit[1] || id_rt_hit[1]
                      || ((WB_BYPASS == 0) && (id_rs_hit[2] || id_rt_hit[2]));
    assign hazard   = id_valid && ((FWD_EN != 0) ? load_use : raw_any);

    // Shadow is cleared by reset, so only the branch input needs explicit gating.
    assign flush = reset && branch_taken;
    assign stall = hazard && !flush;

    assign pc_hold      = stall;
    assign if_id_hold   = stall;
    assign id_ex_bubble = stall || flush;
    assign if_id_flush  = flush;
    assign ex_mem_flush = flush;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if ((FWD_EN != 0) && s_ex.valid) begin
            fwd_a = pick_fwd(ex_rs_hit[0], s_mem.mem_read, ex_rs_hit[1]);
            fwd_b = pick_fwd(ex_rt_hit[0], s_mem.mem_read, ex_rt_hit[1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ex      <= SHADOW_NONE;
            s_mem     <= SHADOW_NONE;
            s_wb      <= SHADOW_NONE;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            s_wb  <= s_mem;
            s_mem <= flush ? SHADOW_NONE : s_ex;
            s_ex  <= (id_valid && !stall && !flush) ? id_entry : SHADOW_NONE;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: three configurations (forwarding, no forwarding,
// no forwarding without WB bypass) fed the same inputs, directed vectors plus a random run.
module tb_pipe_hazard_unit;
    import mips_pipe_pkg::*;

    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       pc_hold [ND];
    logic       if_id_hold [ND];
    logic       if_id_flush [ND];
    logic       id_ex_bubble [ND];
    logic       ex_mem_flush [ND];
    logic [1:0] fwd_a [ND];
    logic [1:0] fwd_b [ND];
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [2:0]  sc2, fc2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.RA_W(5), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .pc_hold(pc_hold[0]), .if_id_hold(if_id_hold[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_bubble(id_ex_bubble[0]), .ex_mem_flush(ex_mem_flush[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_unit #(.RA_W(5), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .pc_hold(pc_hold[1]), .if_id_hold(if_id_hold[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_bubble(id_ex_bubble[1]), .ex_mem_flush(ex_mem_flush[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_unit #(.RA_W(5), .FWD_EN(0), .WB_BYPASS(0), .CNT_W(3)) u2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .pc_hold(pc_hold[2]), .if_id_hold(if_id_hold[2]), .if_id_flush(if_id_flush[2]),
        .id_ex_bubble(id_ex_bubble[2]), .ex_mem_flush(ex_mem_flush[2]),
        .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    // Expected-output word: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_flush, fwd_a, fwd_b}
    localparam logic [8:0] E_0     = 9'b0_0_0_0_0_00_00;
    localparam logic [8:0] E_STALL = 9'b1_1_0_1_0_00_00;
    localparam logic [8:0] E_FLUSH = 9'b0_0_1_1_1_00_00;
    localparam logic [8:0] E_FA10  = 9'b0_0_0_0_0_10_00;
    localparam logic [8:0] E_FA01  = 9'b0_0_0_0_0_01_00;
    localparam logic [8:0] E_FAB01 = 9'b0_0_0_0_0_01_01;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] rd;
        logic       rw, mr, bt;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        bit v;
        int rs, rt;
        bit urs, urt;
        int rd;
        bit rw, mr;
    } minst_t;

    vec_t   tbl [19];
    minst_t mp [ND][3];   // per configuration: distance 0 = EX, 1 = MEM, 2 = WB
    int     m_sc [ND];
    int     m_fc [ND];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs(input int k);
        return int'({pc_hold[k], if_id_hold[k], if_id_flush[k], id_ex_bubble[k],
                     ex_mem_flush[k], fwd_a[k], fwd_b[k]});
    endfunction

    function automatic int scnt(input int k);
        if (k == 0) return int'(sc0);
        if (k == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    function automatic int fcnt(input int k);
        if (k == 0) return int'(fc0);
        if (k == 1) return int'(fc1);
        return int'(fc2);
    endfunction

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic bt,
                                input logic [8:0] exp);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.rd = rd; r.rw = rw; r.mr = mr; r.bt = bt; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic bt);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; branch_taken = bt;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        nop();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        next();
    endtask

    // Reference model helpers: a writer feeds source r only if it really writes a nonzero r.
    function automatic bit writes(input minst_t w, input int r, input bit used);
        return w.v && w.rw && used && (w.rd == r) && (r != 0);
    endfunction

    function automatic int m_fwd(input int k, input int r, input bit used);
        if (k != 0 || !mp[k][0].v) return 0;
        if (writes(mp[k][1], r, used) && !mp[k][1].mr) return 2;
        if (writes(mp[k][2], r, used)) return 1;
        return 0;
    endfunction

    function automatic bit m_stall(input int k, input minst_t id, input bit bt);
        bit h = 0;
        int depth = (k == 2) ? 3 : 2;
        if (bt || !id.v) return 0;
        if (k == 0)
            h = mp[k][0].mr && (writes(mp[k][0], id.rs, id.urs) || writes(mp[k][0], id.rt, id.urt));
        else
            for (int d = 0; d < depth; d++)
                h = h || writes(mp[k][d], id.rs, id.urs) || writes(mp[k][d], id.rt, id.urt);
        return h;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int holds [ND];
        minst_t id, empty;
        bit st, bt, bad;
        int exp_w, cmax;

        reset = 1'b1;
        nop();

        // Reset state, with branch_taken and id_valid driven during reset.
        @(negedge clk);
        reset = 1'b0;
        drive(1, 1, 2, 1, 1, 3, 1, 1, 1);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("reset_outs_k%0d", k), outs(k), 0);
            check($sformatf("reset_stall_cnt_k%0d", k), scnt(k), 0);
            check($sformatf("reset_flush_cnt_k%0d", k), fcnt(k), 0);
        end
        nop();
        @(negedge clk);
        reset = 1'b1;
        next();

        // Directed vectors, forwarding configuration.
        tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, E_0);     // add $3,$1,$2
        tbl[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, E_0);     // sub $4,$3,$5
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FA10);  // sub in EX, add in MEM
        tbl[3]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, E_0);     // add $3,$1,$2
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_0);     // nop
        tbl[5]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, E_0);     // sub $4,$3,$5
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FA01);  // sub in EX, add in WB
        tbl[7]  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, E_0);     // lw $2,0($1)
        tbl[8]  = mk(1, 2, 2, 1, 1, 4, 1, 0, 0, E_STALL); // add $4,$2,$2 load-use
        tbl[9]  = mk(1, 2, 2, 1, 1, 4, 1, 0, 0, E_0);     // same add, issues
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FAB01); // add in EX, lw in WB
        tbl[11] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, E_0);     // lw $0,0($1)
        tbl[12] = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, E_0);     // add $0,$0,$0
        tbl[13] = mk(1, 0, 0, 1, 1, 5, 1, 0, 0, E_0);     // or $5,$0,$0
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_0);     // $0 writers in MEM/WB: no forward
        tbl[15] = mk(1, 1, 0, 1, 0, 7, 1, 1, 0, E_0);     // lw $7,0($1)
        tbl[16] = mk(1, 7, 7, 1, 1, 8, 1, 0, 1, E_FLUSH); // load-use + taken branch
        tbl[17] = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, E_0);     // lw gone from EX: no stall
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_0);     // lw gone from MEM: no WB forward
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].rd,
                  tbl[i].rw, tbl[i].mr, tbl[i].bt);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(0), int'(tbl[i].exp));
            next();
        end
        check("vec_stall_cnt", scnt(0), 1);
        check("vec_flush_cnt", fcnt(0), 1);

        // RAW without forwarding: add $3 then or $6,$3,$0 held in ID.
        do_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        next();
        for (int k = 0; k < ND; k++) holds[k] = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 3, 0, 1, 1, 6, 1, 0, 0);
            @(negedge clk);
            for (int k = 0; k < ND; k++) holds[k] += int'(pc_hold[k]);
            for (int k = 1; k < ND; k++)
                check($sformatf("raw_fwd_k%0d_c%0d", k, c), int'({fwd_a[k], fwd_b[k]}), 0);
            next();
        end
        check("raw_stalls_k0", holds[0], 0);
        check("raw_stalls_k1", holds[1], 2);
        check("raw_stalls_k2", holds[2], 3);
        nop();
        next();
        check("raw_stall_cnt_k1", scnt(1), 2);
        check("raw_stall_cnt_k2", scnt(2), 3);

        // Register 0 writer then reader, non-forwarding configurations.
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0);
        next();
        drive(1, 0, 0, 1, 1, 5, 1, 0, 0);
        @(negedge clk);
        check("zero_k1", outs(1), 0);
        check("zero_k2", outs(2), 0);
        next();

        // Reset asserted in the middle of a stall.
        do_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        next();
        drive(1, 3, 0, 1, 1, 6, 1, 0, 0);
        @(negedge clk);
        check("pre_rst_hold_k1", int'(pc_hold[1]), 1);
        #2;
        reset = 1'b0;
        branch_taken = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) check($sformatf("mid_rst_outs_k%0d", k), outs(k), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        nop();
        next();
        check("post_rst_stall_cnt_k1", scnt(1), 0);
        drive(1, 3, 0, 1, 1, 6, 1, 0, 0);
        @(negedge clk);
        check("post_rst_hold_k1", int'(pc_hold[1]), 0);
        check("post_rst_hold_k2", int'(pc_hold[2]), 0);
        next();

        // Counter saturation (k2 counters are 3 bits wide).
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
            next();
            for (int c = 0; c < 4; c++) begin
                drive(1, 3, 0, 1, 1, 6, 1, 0, 0);
                next();
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            check($sformatf("flush_no_hold_%0d", i), int'(pc_hold[2]), 0);
            next();
        end
        nop();
        next();
        check("sat_stall_k1", scnt(1), 12);
        check("sat_flush_k1", fcnt(1), 10);
        check("sat_stall_k2", scnt(2), 7);
        check("sat_flush_k2", fcnt(2), 7);

        // Random stimulus against the reference model.
        do_reset();
        empty = '{default: 0};
        for (int k = 0; k < ND; k++) begin
            for (int d = 0; d < 3; d++) mp[k][d] = empty;
            m_sc[k] = 0;
            m_fc[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id.v   = ($urandom_range(0, 9) != 0);
            id.rs  = int'($urandom_range(0, 3));
            id.rt  = int'($urandom_range(0, 3));
            id.urs = 1'($urandom_range(0, 3) != 0);
            id.urt = 1'($urandom_range(0, 1));
            id.rd  = int'($urandom_range(0, 3));
            id.rw  = ($urandom_range(0, 3) != 0);
            id.mr  = id.rw && ($urandom_range(0, 2) == 0);
            bt     = ($urandom_range(0, 9) == 0);
            drive(id.v, 5'(id.rs), 5'(id.rt), id.urs, id.urt, 5'(id.rd), id.rw, id.mr, bt);
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                st = m_stall(k, id, bt);
                exp_w = (int'(st) << 8) | (int'(st) << 7) | (int'(bt) << 6)
                      | (int'(st || bt) << 5) | (int'(bt) << 4)
                      | (m_fwd(k, mp[k][0].rs, mp[k][0].urs) << 2)
                      | m_fwd(k, mp[k][0].rt, mp[k][0].urt);
                check($sformatf("rnd%0d_k%0d_outs", cyc, k), outs(k), exp_w);
                check($sformatf("rnd%0d_k%0d_stall_cnt", cyc, k), scnt(k), m_sc[k]);
                check($sformatf("rnd%0d_k%0d_flush_cnt", cyc, k), fcnt(k), m_fc[k]);
                bad = mp[k][0].v && mp[k][1].mr
                      && (writes(mp[k][1], mp[k][0].rs, mp[k][0].urs)
                          || writes(mp[k][1], mp[k][0].rt, mp[k][0].urt));
                compared++;
                a_no_load_in_mem: assert (!bad) else begin
                    mismatched++;
                    $display("FAIL load_in_mem cyc%0d k%0d: got load feeding EX, required none", cyc, k);
                end
                cmax = (k == 2) ? 7 : 65535;
                mp[k][2] = mp[k][1];
                mp[k][1] = bt ? empty : mp[k][0];
                mp[k][0] = (id.v && !st && !bt) ? id : empty;
                if (st && m_sc[k] < cmax) m_sc[k]++;
                if (bt && m_fc[k] < cmax) m_fc[k]++;
            end
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
